tick_period_monitor: RTL and testbench
======================================

# tick_period_monitor

Receive-side checker for the divided tick clock produced by the alarm-clock divider. It synchronizes the incoming tick clock into the `clk` domain and detects its rising edges. It measures each tick period in `clk` cycles and declares lock once consecutive periods match the expected divider ratio. A lost or malformed tick raises a sticky fault, which the alarm/timekeeping logic uses to qualify its time base.

## Interface
- EXPECT_PERIOD, 6: expected tick period in `clk` cycles (≥ 2).
- TOLERANCE, 0: allowed ± deviation of a measured period from EXPECT_PERIOD.
- LOCK_COUNT, 4: consecutive in-tolerance periods required to lock (1..15).
- CNT_W, 8: width of the period counter; 2^CNT_W−1 must exceed 2·EXPECT_PERIOD.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-low.
- tick_in  input  1  divided tick clock; treated as asynchronous.
- clr  input  1  synchronous clear of state, fault and counters (active-high).
- edge_pulse  output  1  one-cycle strobe per synchronized rising edge of tick_in.
- period_out  output  CNT_W  last measured period in `clk` cycles.
- period_valid  output  1  one-cycle strobe when period_out updates.
- locked  output  1  high in LOCKED state.
- fault  output  1  sticky; high in FAULT state.
- duty_err  output  1  sticky high-time error (see Configuration).
- tick_cnt  output  16  rising edges counted while LOCKED.

## Operation
- Input path: 2-flop synchronizer (s1, s2), then a history flop s3. Rising edge = s2 & ~s3; falling edge = ~s2 & s3.
- Period counter `pc`:
  - loads 1 on a rising edge;
  - otherwise increments, saturating at 2^CNT_W−1.
- On every rising edge except the first after reset/clr: period_out ← pc; period_valid = 1 for that cycle.
- A measured period P is a match if |P − EXPECT_PERIOD| ≤ TOLERANCE. A saturated P is always a mismatch.
- Match counter `mc` (4 bits) counts consecutive matches in ACQUIRE.
- FSM, all transitions on `clk`:
  - IDLE: no edge seen yet. First rising edge → ACQUIRE; no period is reported.
  - ACQUIRE: on a match, mc+1, and mc reaching LOCK_COUNT → LOCKED. On a mismatch, mc ← 0 and the state stays ACQUIRE.
  - LOCKED: a mismatch → FAULT. Timeout (pc reaches 2·EXPECT_PERIOD with no edge) → FAULT. Each rising edge increments tick_cnt, wrapping 65535 → 0.
  - FAULT: fault = 1, locked = 0; edges are still measured and reported, and tick_cnt is frozen. Exits only via clr or rst.
- clr:
  - returns the FSM to IDLE;
  - zeroes mc, pc, tick_cnt, period_out, fault and duty_err;
  - keeps the synchronizer flops running.
- Priority: rst > clr > edge/timeout events in the same cycle.
- Reset values: every output 0, FSM IDLE, all counters and synchronizer flops 0.

## Timing
- tick_in rises and is first sampled high at clk edge N → s1 at N, s2 at N+1, edge_pulse high during the cycle after N+2 edge, for exactly one cycle.
- period_valid, period_out and the FSM transition caused by that edge update on the same edge as edge_pulse.
- locked rises on the edge that registers the LOCK_COUNT-th consecutive match. With ideal input that is the (LOCK_COUNT+1)-th rising edge.
- Timeout fires on the edge where pc becomes 2·EXPECT_PERIOD. fault is visible the following cycle.
- Input requirement: tick_in high and low phases each ≥ 2 `clk` cycles. Shorter pulses may be dropped; this is not a fault by itself, but the resulting period mismatch is.

## Configuration
- TICK_MON_DUTY_CHECK_EN defined:
  - a high-time counter loads 1 on a rising edge and increments while s2 is high;
  - on a falling edge, a high time outside floor(EXPECT_PERIOD/2) ± TOLERANCE sets duty_err (sticky until clr/rst);
  - in LOCKED, a duty_err setting event also forces FAULT.
- Undefined: no high-time logic is built, duty_err is tied 0, and only periods are checked.

## Test plan
- Ideal 6-cycle tick (3 high/3 low), LOCK_COUNT=4 → period_valid strobes with period_out=6; locked=1 after the 5th rising edge; fault=0; tick_cnt increments per edge.
- After lock, a single 7-cycle period with TOLERANCE=0 → fault=1, locked=0 on that edge; tick_cnt frozen.
- After lock, tick_in held low → fault=1 exactly when pc reaches 12; period_out unchanged.
- In ACQUIRE, the sequence 6,6,5,6,6,6,6 → mc resets at the 5 and locked asserts only after the fourth 6 that follows it.
- clr asserted in the same cycle as a rising edge while in FAULT → IDLE and all counters 0; the next edge is treated as the first (no period_valid).
- With TICK_MON_DUTY_CHECK_EN: locked, then a 6-cycle period with 1 high/5 low → duty_err=1 and fault=1; without the macro the same stimulus keeps locked=1 and duty_err=0.

Source files
------------

// File: rtl/tick_period_monitor.sv
// Tick clock receiver: synchronizes tick_in, measures periods, tracks lock/fault.
// Define TICK_MON_DUTY_CHECK_EN to also build the high-time (duty) check.
module tick_period_monitor #(
  parameter int unsigned EXPECT_PERIOD = 6,
  parameter int unsigned TOLERANCE     = 0,
  parameter int unsigned LOCK_COUNT    = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             clr,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             fault,
  output logic             duty_err,
  output logic [15:0]      tick_cnt
);
  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED,
    FAULT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(2 * EXPECT_PERIOD);
  localparam int unsigned P_LO =
    (EXPECT_PERIOD > TOLERANCE) ? EXPECT_PERIOD - TOLERANCE : 0;
  localparam int unsigned P_HI = EXPECT_PERIOD + TOLERANCE;
  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  state_e           state_d, state_q;
  logic             s1_d, s1_q;
  logic             s2_d, s2_q;
  logic             s3_d, s3_q;
  logic [CNT_W-1:0] pc_d, pc_q;
  logic [CNT_W-1:0] period_d, period_q;
  logic             period_valid_d, period_valid_q;
  logic             edge_pulse_d, edge_pulse_q;
  logic [3:0]       mc_d, mc_q;
  logic [3:0]       mc_inc;
  logic [15:0]      tick_cnt_d, tick_cnt_q;
  logic             rise;
  logic             match;
  logic             duty_evt;
  logic [31:0]      pc_ext;

  assign s1_d   = tick_in;
  assign s2_d   = s1_q;
  assign s3_d   = s2_q;
  assign rise   = s2_q & ~s3_q;
  assign pc_ext = 32'(pc_q);
  // A saturated count means the edge was lost, never a valid period
  assign match  = (pc_q != CNT_MAX) &&
                  (pc_ext >= P_LO) && (pc_ext <= P_HI);

  always_comb begin
    state_d        = state_q;
    mc_d           = mc_q;
    tick_cnt_d     = tick_cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    edge_pulse_d   = rise;
    mc_inc         = mc_q + 4'd1;
    if (rise)
      pc_d = CNT_W'(1);
    else if (pc_q == CNT_MAX)
      pc_d = pc_q;
    else
      pc_d = pc_q + CNT_W'(1);
    if (rise && state_q != IDLE) begin
      period_valid_d = 1'b1;
      period_d       = pc_q;
    end
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = ACQUIRE;
          mc_d    = '0;
        end
      end
      ACQUIRE: begin
        if (rise) begin
          if (match) begin
            mc_d = mc_inc;
            if (mc_inc == LOCK_N)
              state_d = LOCKED;
          end else begin
            mc_d = '0;
          end
        end
      end
      LOCKED: begin
        if (rise) begin
          tick_cnt_d = tick_cnt_q + 16'd1;
          if (!match)
            state_d = FAULT;
        end else if (pc_d == TO_LIM) begin
          state_d = FAULT;
        end
        if (duty_evt)
          state_d = FAULT;
      end
      FAULT: begin
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d        = IDLE;
      mc_d           = '0;
      pc_d           = '0;
      tick_cnt_d     = '0;
      period_d       = '0;
      period_valid_d = 1'b0;
      edge_pulse_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      pc_q           <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      edge_pulse_q   <= 1'b0;
      mc_q           <= '0;
      tick_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      pc_q           <= pc_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      edge_pulse_q   <= edge_pulse_d;
      mc_q           <= mc_d;
      tick_cnt_q     <= tick_cnt_d;
    end
  end

`ifdef TICK_MON_DUTY_CHECK_EN
  localparam int unsigned H_NOM = EXPECT_PERIOD / 2;
  localparam int unsigned H_LO  =
    (H_NOM > TOLERANCE) ? H_NOM - TOLERANCE : 0;
  localparam int unsigned H_HI  = H_NOM + TOLERANCE;

  logic             fall;
  logic [CNT_W-1:0] hc_d, hc_q;
  logic             duty_err_d, duty_err_q;
  logic [31:0]      hc_ext;

  assign fall   = ~s2_q & s3_q;
  assign hc_ext = 32'(hc_q);
  // Before the first edge the high-time count is not anchored to a rise
  assign duty_evt = fall && (state_q != IDLE) &&
                    ((hc_ext < H_LO) || (hc_ext > H_HI));

  always_comb begin
    hc_d = hc_q;
    if (rise)
      hc_d = CNT_W'(1);
    else if (s2_q && hc_q != CNT_MAX)
      hc_d = hc_q + CNT_W'(1);
    duty_err_d = duty_err_q | duty_evt;
    if (clr) begin
      hc_d       = '0;
      duty_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hc_q       <= '0;
      duty_err_q <= 1'b0;
    end else begin
      hc_q       <= hc_d;
      duty_err_q <= duty_err_d;
    end
  end

  assign duty_err = duty_err_q;
`else
  assign duty_evt = 1'b0;
  assign duty_err = 1'b0;
`endif

  assign edge_pulse   = edge_pulse_q;
  assign period_out   = period_q;
  assign period_valid = period_valid_q;
  assign locked       = (state_q == LOCKED);
  assign fault        = (state_q == FAULT);
  assign tick_cnt     = tick_cnt_q;

endmodule

// File: tb/tb_tick_period_monitor.sv
// Bench for tick_period_monitor: timestamp-based model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_tick_period_monitor;
  localparam int E  = 6;
  localparam int T  = 0;
  localparam int LC = 4;
  localparam int W  = 8;
  localparam int SAT = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         tick_in = 1'b0;
  logic         clr = 1'b0;
  logic         edge_pulse;
  logic [W-1:0] period_out;
  logic         period_valid;
  logic         locked;
  logic         fault;
  logic         duty_err;
  logic [15:0]  tick_cnt;

  always #5 clk = ~clk;

  tick_period_monitor #(
    .EXPECT_PERIOD(E),
    .TOLERANCE(T),
    .LOCK_COUNT(LC),
    .CNT_W(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick_in(tick_in),
    .clr(clr),
    .edge_pulse(edge_pulse),
    .period_out(period_out),
    .period_valid(period_valid),
    .locked(locked),
    .fault(fault),
    .duty_err(duty_err),
    .tick_cnt(tick_cnt)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: input samples by cycle index, periods as timestamp differences
  int  cyc = 0;
  bit  smp [0:8191];
  int  last_rise = 0;
  bit  started = 0;
  bit  m_locked = 0;
  bit  m_fault = 0;
  bit  m_duty = 0;
  bit  m_ep = 0;
  bit  m_pv = 0;
  int  streak = 0;
  int  m_tick = 0;
  int  m_period = 0;
  bit  checking = 0;

  function automatic bit s_at(input int i);
    return (i < 0) ? 1'b0 : smp[i];
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_clear(input int t);
    started   = 0;
    m_locked  = 0;
    m_fault   = 0;
    m_duty    = 0;
    m_ep      = 0;
    m_pv      = 0;
    streak    = 0;
    m_tick    = 0;
    m_period  = 0;
    last_rise = t + 1;
  endtask

  always @(posedge clk) begin
    automatic int t = cyc;
    automatic bit rise;
    automatic bit fall;
    automatic bit match;
    automatic int pcval;
    smp[t] = rst ? tick_in : 1'b0;
    rise = s_at(t - 2) && !s_at(t - 3);
    fall = !s_at(t - 2) && s_at(t - 3);
    pcval = t - last_rise;
    if (pcval > SAT) pcval = SAT;
    if (!rst || clr) begin
      model_clear(t);
    end else begin
      m_ep = rise;
      m_pv = 0;
      if (rise) begin
        if (!started) begin
          started = 1;
        end else begin
          m_pv = 1;
          m_period = pcval;
          match = (pcval != SAT) && (iabs(pcval - E) <= T);
          if (m_fault) begin
          end else if (m_locked) begin
            m_tick = (m_tick + 1) % 65536;
            if (!match) begin
              m_locked = 0;
              m_fault = 1;
            end
          end else if (match) begin
            streak++;
            if (streak == LC) m_locked = 1;
          end else begin
            streak = 0;
          end
        end
        last_rise = t;
      end else if (m_locked && pcval + 1 == 2 * E) begin
        m_locked = 0;
        m_fault = 1;
      end
`ifdef TICK_MON_DUTY_CHECK_EN
      if (fall && started && iabs(pcval - E / 2) > T) begin
        m_duty = 1;
        if (m_locked) begin
          m_locked = 0;
          m_fault = 1;
        end
      end
`else
      if (fall && 1'b0) m_duty = 1;
`endif
    end
    cyc++;
    checking = 1;
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("edge_pulse", 32'(edge_pulse), 32'(m_ep));
      chk("period_valid", 32'(period_valid), 32'(m_pv));
      chk("period_out", 32'(period_out), 32'(m_period));
      chk("locked", 32'(locked), 32'(m_locked));
      chk("fault", 32'(fault), 32'(m_fault));
      chk("duty_err", 32'(duty_err), 32'(m_duty));
      chk("tick_cnt", 32'(tick_cnt), 32'(m_tick));
    end
  end

  task automatic drive(input int hi, input int lo);
    tick_in = 1'b1;
    repeat (hi) @(negedge clk);
    tick_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_period", 32'(period_out), 32'd0);
    chk("rst_tick", 32'(tick_cnt), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    repeat (8) drive(3, 3);
    chk("ideal_locked", 32'(locked), 32'd1);
    chk("ideal_fault", 32'(fault), 32'd0);
    chk("ideal_period", 32'(period_out), 32'd6);
    chk("ideal_tick", 32'(tick_cnt), 32'd3);

    drive(3, 4);
    drive(3, 3);
    chk("p7_fault", 32'(fault), 32'd1);
    chk("p7_locked", 32'(locked), 32'd0);
    chk("p7_period", 32'(period_out), 32'd7);
    chk("p7_tick", 32'(tick_cnt), 32'd5);
    drive(3, 3);
    chk("flt_period", 32'(period_out), 32'd6);
    chk("flt_tick", 32'(tick_cnt), 32'd5);

    tick_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_tick", 32'(tick_cnt), 32'd0);
    chk("clr_period", 32'(period_out), 32'd0);
    drive(3, 3);
    chk("clr_first", 32'(period_out), 32'd0);
    repeat (4) drive(3, 3);
    chk("relock", 32'(locked), 32'd1);
    chk("relock_tick", 32'(tick_cnt), 32'd0);

    tick_in = 1'b0;
    repeat (20) @(negedge clk);
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_period", 32'(period_out), 32'd6);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    drive(3, 3);
    drive(3, 3);
    drive(3, 2);
    repeat (4) drive(3, 3);
    chk("acq_not_yet", 32'(locked), 32'd0);
    drive(3, 3);
    chk("acq_locked", 32'(locked), 32'd1);

    drive(1, 5);
    drive(3, 3);
`ifdef TICK_MON_DUTY_CHECK_EN
    chk("duty_err", 32'(duty_err), 32'd1);
    chk("duty_fault", 32'(fault), 32'd1);
    chk("duty_tick", 32'(tick_cnt), 32'd1);
`else
    chk("duty_off_err", 32'(duty_err), 32'd0);
    chk("duty_off_lock", 32'(locked), 32'd1);
    chk("duty_off_tick", 32'(tick_cnt), 32'd2);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
